seq_divider16: RTL and testbench

- Sequential unsigned restoring divider: one quotient bit per clock.
- Complements the team's combinational adder/subtractor chain. It produces quotient and remainder by repeated trial subtraction instead of forming sums or differences.
- Used by datapath blocks that need division without a large combinational array.
- Simple start/busy/done handshake.

---
 rtl/seq_divider16_pkg.sv | 15 +
 rtl/seq_divider16_div_trial_sub.sv | 46 ++++
 rtl/seq_divider16.sv | 138 +++++++++++++
 tb/tb_seq_divider16.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider16_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider16_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [DEF_WIDTH-1:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/seq_divider16_div_trial_sub.sv
// Ripple trial subtractor a - b, formed as a + ~b + 1 from full-adder cells.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  // Single-bit sum and carry.
  always_comb begin
    o_s = i_a ^ i_b ^ i_c;
    o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
  end
endmodule

module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_nonneg
);
  logic [WIDTH+1:0] w_carry;
  logic [WIDTH:0]   w_b_inv;

  // Carry-in of one completes the two's-complement negation of b.
  always_comb begin
    w_carry[0] = 1'b1;
    w_b_inv    = ~i_b;
  end

  for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
    full_adder u_fa (
      .i_a (i_a[g]),
      .i_b (w_b_inv[g]),
      .i_c (w_carry[g]),
      .o_s (o_diff[g]),
      .o_c (w_carry[g+1])
    );
  end

  // Carry out of the top cell means no borrow, i.e. a >= b.
  always_comb o_nonneg = w_carry[WIDTH+1];
endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one trial subtraction per edge, WIDTH edges total
// DONE  | done pulse for one cycle, then back to IDLE
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // All ones at whatever WIDTH this instance uses.
  localparam logic [WIDTH-1:0] L_DBZ_QUOT = {WIDTH{QUOT_ALL_ONES[0]}};
  localparam logic [CNT_W-1:0] L_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_nonneg;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;

  // The full partial remainder is kept in the shift so that a remainder with
  // its top bit set (possible with large divisors) still compares correctly.
  always_comb w_shifted = {r_rem, r_dvd[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .i_a      (w_shifted),
    .i_b      ({1'b0, r_divisor}),
    .o_diff   (w_trial),
    .o_nonneg (w_nonneg)
  );

  // Quotient bit and restored/updated remainder for this iteration; the
  // difference sign bit and the adder carry agree for in-range operands.
  always_comb begin
    w_qbit    = w_nonneg & ~w_trial[WIDTH];
    w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    w_last    = (r_cnt == L_LAST_CNT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      if (divisor == '0) begin
        r_quot    <= L_DBZ_QUOT;
        r_rem_out <= dividend;
        r_dbz     <= 1'b1;
      end else begin
        r_dvd     <= dividend;
        r_rem     <= '0;
        r_divisor <= divisor;
        r_cnt     <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot    <= {r_dvd[WIDTH-2:0], w_qbit};
        r_rem_out <= w_rem_nxt;
        r_dbz     <= 1'b0;
      end
    end
  end

  // Result ports.
  always_comb begin
    quotient    = r_quot;
    remainder   = r_rem_out;
    div_by_zero = r_dbz;
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed bench for seq_divider16: handshake timing, corner operands,
// mid-operation reset, held start and an invariant sweep.
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done; operands are scrambled
  // right after the start edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int cyc, output int nbusy);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    cyc      = 0;
    nbusy    = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) nbusy++;
      tick();
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_done_excl", {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_op;
    tick();
    check("done_pulse_len", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          nb;
    int          ndone;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic [15:0] h_a[54];
    logic [15:0] h_b[54];

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", {16'd0, quotient}, 32'd0);
    check("rst_rem",  {16'd0, remainder}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();

    // 100 / 7 = 14 r 2
    run_op(16'd100, 16'd7, cyc, nb);
    check("d100_latency", cyc, 32'd16);
    check("d100_busy_cycles", nb, 32'd16);
    check("d100_quot", {16'd0, quotient}, 32'd14);
    check("d100_rem",  {16'd0, remainder}, 32'd2);
    check("d100_dbz",  {31'd0, div_by_zero}, 32'd0);
    finish_op();
    repeat (3) tick();
    check("d100_hold_quot", {16'd0, quotient}, 32'd14);
    check("d100_hold_rem",  {16'd0, remainder}, 32'd2);

    // 1234 / 0: done right after the start edge, no busy
    run_op(16'd1234, 16'd0, cyc, nb);
    check("dbz_latency", cyc, 32'd0);
    check("dbz_busy_cycles", nb, 32'd0);
    check("dbz_quot", {16'd0, quotient}, 32'h0000FFFF);
    check("dbz_rem",  {16'd0, remainder}, 32'd1234);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    finish_op();

    // 0xFFFF / 0xFFFF = 1 r 0
    run_op(16'hFFFF, 16'hFFFF, cyc, nb);
    check("ffff_ffff_quot", {16'd0, quotient}, 32'd1);
    check("ffff_ffff_rem",  {16'd0, remainder}, 32'd0);
    check("ffff_ffff_dbz",  {31'd0, div_by_zero}, 32'd0);
    finish_op();

    // 0xFFFF / 1 = 0xFFFF r 0
    run_op(16'hFFFF, 16'd1, cyc, nb);
    check("ffff_1_quot", {16'd0, quotient}, 32'h0000FFFF);
    check("ffff_1_rem",  {16'd0, remainder}, 32'd0);
    finish_op();

    // 5 / 9 = 0 r 5
    run_op(16'd5, 16'd9, cyc, nb);
    check("5_9_quot", {16'd0, quotient}, 32'd0);
    check("5_9_rem",  {16'd0, remainder}, 32'd5);
    finish_op();

    // 0xFFFE / 0xFFFF = 0 r 0xFFFE (remainder with top bit set)
    run_op(16'hFFFE, 16'hFFFF, cyc, nb);
    check("fffe_ffff_quot", {16'd0, quotient}, 32'd0);
    check("fffe_ffff_rem",  {16'd0, remainder}, 32'h0000FFFE);
    finish_op();

    // Reset in the middle of 1000 / 3
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quot", {16'd0, quotient}, 32'd0);
    check("midrst_rem",  {16'd0, remainder}, 32'd0);
    check("midrst_dbz",  {31'd0, div_by_zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);
    run_op(16'd1000, 16'd3, cyc, nb);
    check("d1000_quot", {16'd0, quotient}, 32'd333);
    check("d1000_rem",  {16'd0, remainder}, 32'd1);
    finish_op();

    // start held high with operands changing every cycle: accepts at edges
    // 0, 18, 36; results appear after edges 16, 34, 52.
    for (int i = 0; i < 54; i++) begin
      h_a[i]   = 16'(500 + 97 * i);
      h_b[i]   = 16'(1 + (i * 7) % 13);
      start    = 1'b1;
      dividend = h_a[i];
      divisor  = h_b[i];
      tick();
      check("held_busy", {31'd0, busy}, {31'd0, (i % 18) < 16});
      if (i >= 16 && (i - 16) % 18 == 0) begin
        check("held_done", {31'd0, done}, 32'd1);
        check("held_quot", {16'd0, quotient},  {16'd0, 16'(h_a[i-16] / h_b[i-16])});
        check("held_rem",  {16'd0, remainder}, {16'd0, 16'(h_a[i-16] % h_b[i-16])});
      end else begin
        check("held_no_done", {31'd0, done}, 32'd0);
      end
    end
    start = 1'b0;
    tick();

    // Invariant sweep: random pairs, zero dividends, power-of-two divisors
    for (int k = 0; k < 160; k++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      if (k % 10 == 0) a = 16'd0;
      if (k % 7 == 0)  b = 16'd1 << (k % 16);
      run_op(a, b, cyc, nb);
      prod = 32'(quotient) * 32'(b) + 32'(remainder);
      check("inv_eq", prod, {16'd0, a});
      check("inv_rem_lt", {31'd0, remainder < b}, 32'd1);
      check("inv_latency", cyc, 32'd16);
      finish_op();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
